// File: rtl/id_stage_if.sv
// Signal bundle between the decode stage and its pipeline neighbours (fetch, EX, MEM, WB).
interface id_stage_if;
    logic [31:0] pc_IfId;
    logic [31:0] instr_IfId;
    logic        ex_wen;
    logic        ex_isload;
    logic [4:0]  ex_wreg;
    logic        mem_wen;
    logic        mem_isload;
    logic [4:0]  mem_wreg;
    logic [31:0] mem_data;
    logic        wb_wen;
    logic [4:0]  wb_wreg;
    logic [31:0] wb_data;
    logic        ifStall;
    logic        ifBranchOrJump_Id;
    logic [31:0] pc_Id;
    logic [31:0] pc_IdEx;
    logic [31:0] instr_IdEx;
    logic [31:0] rs_IdEx;
    logic [31:0] rt_IdEx;
    logic [31:0] ext_IdEx;

    modport master (
        output pc_IfId, instr_IfId, ex_wen, ex_isload, ex_wreg,
               mem_wen, mem_isload, mem_wreg, mem_data, wb_wen, wb_wreg, wb_data,
        input  ifStall, ifBranchOrJump_Id, pc_Id, pc_IdEx, instr_IdEx,
               rs_IdEx, rt_IdEx, ext_IdEx
    );

    modport slave (
        input  pc_IfId, instr_IfId, ex_wen, ex_isload, ex_wreg,
               mem_wen, mem_isload, mem_wreg, mem_data, wb_wen, wb_wreg, wb_data,
        output ifStall, ifBranchOrJump_Id, pc_Id, pc_IdEx, instr_IdEx,
               rs_IdEx, rt_IdEx, ext_IdEx
    );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID and ID/EX registers, GRF with write-through, operand forwarding,
// branch/jump resolution and load-use / branch-operand stalling.
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned NREGS    = 32
) (
    input logic       clk,
    input logic       reset,
    id_stage_if.slave bus
);
    typedef enum logic [3:0] {
        OpNone, OpAddu, OpSubu, OpJr, OpOri, OpLw, OpSw, OpBeq, OpBne, OpLui, OpJ, OpJal
    } op_e;

    logic [31:0] r_pc_ifid;
    logic [31:0] r_instr_ifid;
    logic [31:0] r_grf [NREGS];
    logic [31:0] r_pc_idex;
    logic [31:0] r_instr_idex;
    logic [31:0] r_rs_idex;
    logic [31:0] r_rt_idex;
    logic [31:0] r_ext_idex;

    op_e         w_op;
    logic [4:0]  w_rs_a;
    logic [4:0]  w_rt_a;
    logic [15:0] w_imm;
    logic [31:0] w_pc4;
    logic        w_use_rs;
    logic        w_use_rt;
    logic        w_is_br;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_ext;
    logic        w_stall;
    logic        w_redir;
    logic [31:0] w_target;

    assign w_rs_a = r_instr_ifid[25:21];
    assign w_rt_a = r_instr_ifid[20:16];
    assign w_imm  = r_instr_ifid[15:0];
    assign w_pc4  = r_pc_ifid + 32'd4;

    always_comb begin
        w_op = OpNone;
        case (r_instr_ifid[31:26])
            6'h00: begin
                case (r_instr_ifid[5:0])
                    6'h21:   w_op = OpAddu;
                    6'h23:   w_op = OpSubu;
                    6'h08:   w_op = OpJr;
                    default: w_op = OpNone;
                endcase
            end
            6'h0D:   w_op = OpOri;
            6'h23:   w_op = OpLw;
            6'h2B:   w_op = OpSw;
            6'h04:   w_op = OpBeq;
            6'h05:   w_op = OpBne;
            6'h0F:   w_op = OpLui;
            6'h02:   w_op = OpJ;
            6'h03:   w_op = OpJal;
            default: w_op = OpNone;
        endcase
    end

    assign w_use_rs = w_op inside {OpAddu, OpSubu, OpJr, OpOri, OpLw, OpSw, OpBeq, OpBne};
    assign w_use_rt = w_op inside {OpAddu, OpSubu, OpBeq, OpBne, OpSw};
    assign w_is_br  = w_op inside {OpBeq, OpBne, OpJr};

    // MEM ALU result beats the write-back value; loads in MEM have no data yet.
    function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] grf_val,
                                        input logic m_wen, input logic m_ld,
                                        input logic [4:0] m_reg, input logic [31:0] m_data,
                                        input logic w_wen, input logic [4:0] w_reg,
                                        input logic [31:0] w_data);
        if (s == 5'd0)                            return 32'd0;
        else if (m_wen && !m_ld && m_reg == s)    return m_data;
        else if (w_wen && w_reg == s)             return w_data;
        else                                      return grf_val;
    endfunction

    function automatic logic hazard(input logic [4:0] s, input logic br,
                                    input logic e_wen, input logic e_ld, input logic [4:0] e_reg,
                                    input logic m_wen, input logic m_ld, input logic [4:0] m_reg);
        if (s == 5'd0) return 1'b0;
        if (br)        return (e_wen && e_reg == s) || (m_wen && m_ld && m_reg == s);
        return e_wen && e_ld && e_reg == s;
    endfunction

    assign w_rs_val = fwd(w_rs_a, r_grf[w_rs_a], bus.mem_wen, bus.mem_isload, bus.mem_wreg,
                          bus.mem_data, bus.wb_wen, bus.wb_wreg, bus.wb_data);
    assign w_rt_val = fwd(w_rt_a, r_grf[w_rt_a], bus.mem_wen, bus.mem_isload, bus.mem_wreg,
                          bus.mem_data, bus.wb_wen, bus.wb_wreg, bus.wb_data);

    assign w_stall =
        (w_use_rs && hazard(w_rs_a, w_is_br, bus.ex_wen, bus.ex_isload, bus.ex_wreg,
                            bus.mem_wen, bus.mem_isload, bus.mem_wreg)) ||
        (w_use_rt && hazard(w_rt_a, w_is_br, bus.ex_wen, bus.ex_isload, bus.ex_wreg,
                            bus.mem_wen, bus.mem_isload, bus.mem_wreg));

    always_comb begin
        w_redir  = 1'b0;
        w_target = w_pc4;
        w_ext    = {{16{w_imm[15]}}, w_imm};
        case (w_op)
            OpBeq: begin
                w_redir  = (w_rs_val == w_rt_val);
                w_target = w_pc4 + {{14{w_imm[15]}}, w_imm, 2'b00};
            end
            OpBne: begin
                w_redir  = (w_rs_val != w_rt_val);
                w_target = w_pc4 + {{14{w_imm[15]}}, w_imm, 2'b00};
            end
            OpJ, OpJal: begin
                w_redir  = 1'b1;
                w_target = {w_pc4[31:28], r_instr_ifid[25:0], 2'b00};
            end
            OpJr: begin
                w_redir  = 1'b1;
                w_target = w_rs_val;
            end
            OpOri:   w_ext = {16'h0, w_imm};
            OpLui:   w_ext = {w_imm, 16'h0};
            default: ;
        endcase
        if (w_stall) w_redir = 1'b0;
    end

    assign bus.ifStall           = w_stall;
    assign bus.ifBranchOrJump_Id = w_redir;
    assign bus.pc_Id             = w_redir ? w_target : w_pc4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_ifid    <= RESET_PC;
            r_instr_ifid <= 32'd0;
        end else if (!w_stall) begin
            r_pc_ifid    <= bus.pc_IfId;
            r_instr_ifid <= bus.instr_IfId;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) r_grf[i] <= 32'd0;
        end else if (bus.wb_wen && bus.wb_wreg != 5'd0) begin
            r_grf[bus.wb_wreg] <= bus.wb_data;
        end
    end

    // A stalled cycle sends a bubble down but keeps the ID pc for exception/debug tracing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_idex    <= RESET_PC;
            r_instr_idex <= 32'd0;
            r_rs_idex    <= 32'd0;
            r_rt_idex    <= 32'd0;
            r_ext_idex   <= 32'd0;
        end else begin
            r_pc_idex    <= r_pc_ifid;
            r_instr_idex <= w_stall ? 32'd0 : r_instr_ifid;
            r_rs_idex    <= w_stall ? 32'd0 : w_rs_val;
            r_rt_idex    <= w_stall ? 32'd0 : w_rt_val;
            r_ext_idex   <= w_stall ? 32'd0 : w_ext;
        end
    end

    assign bus.pc_IdEx    = r_pc_idex;
    assign bus.instr_IdEx = r_instr_idex;
    assign bus.rs_IdEx    = r_rs_idex;
    assign bus.rt_IdEx    = r_rt_idex;
    assign bus.ext_IdEx   = r_ext_idex;
endmodule

// File: tb/tb_id_stage.sv
// Directed plus randomized bench for id_stage against an instruction-level reference model.
module tb_id_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage #(
        .RESET_PC (32'h0000_3000),
        .NREGS    (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_grf [32];
    logic [31:0] m_pc, m_ins;
    logic [31:0] x_pc, x_ins, x_rs, x_rt, x_ext;
    bit          e_stall, e_redir;
    logic [31:0] e_pcid, e_rs, e_rt, e_ext;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    // Value the instruction in ID observes for register s this cycle.
    function automatic logic [31:0] fwd(input logic [4:0] s);
        if (s == 0) return 0;
        if (bus.mem_wen && !bus.mem_isload && bus.mem_wreg == s) return bus.mem_data;
        if (bus.wb_wen && bus.wb_wreg == s) return bus.wb_data;
        return m_grf[s];
    endfunction

    // Producer of s cannot deliver its value in time for this consumer.
    function automatic bit blocked(input logic [4:0] s, input bit br);
        if (s == 0) return 0;
        if (bus.ex_wen && bus.ex_wreg == s && (br || bus.ex_isload)) return 1;
        if (br && bus.mem_wen && bus.mem_isload && bus.mem_wreg == s) return 1;
        return 0;
    endfunction

    task automatic predict();
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt;
        logic [15:0] imm;
        logic [31:0] p4, a, b, tgt, idx;
        bit          use_rs, use_rt, br, want;
        op  = m_ins[31:26];
        fn  = m_ins[5:0];
        rs  = m_ins[25:21];
        rt  = m_ins[20:16];
        imm = m_ins[15:0];
        idx = {6'd0, m_ins[25:0]};
        p4  = m_pc + 32'd4;
        a   = fwd(rs);
        b   = fwd(rt);
        use_rs = 0; use_rt = 0; br = 0; want = 0; tgt = p4;
        e_ext = 32'(int'($signed(imm)));
        case (op)
            6'h00: begin
                if (fn == 6'h21 || fn == 6'h23) begin use_rs = 1; use_rt = 1; end
                else if (fn == 6'h08) begin use_rs = 1; br = 1; want = 1; tgt = a; end
            end
            6'h0D: begin use_rs = 1; e_ext = 32'(imm); end
            6'h23: use_rs = 1;
            6'h2B: begin use_rs = 1; use_rt = 1; end
            6'h04, 6'h05: begin
                use_rs = 1; use_rt = 1; br = 1;
                want = (op == 6'h04) ? (a == b) : (a != b);
                tgt  = p4 + 32'(int'($signed(imm)) * 4);
            end
            6'h0F: e_ext = 32'(imm) * 32'd65536;
            6'h02, 6'h03: begin want = 1; tgt = (p4 & 32'hF000_0000) | (idx * 4); end
            default: ;
        endcase
        e_stall = (use_rs && blocked(rs, br)) || (use_rt && blocked(rt, br));
        e_redir = want && !e_stall;
        e_pcid  = e_redir ? tgt : p4;
        e_rs    = a;
        e_rt    = b;
    endtask

    task automatic chk_idex(input string tag);
        chk({tag, "_pc_IdEx"}, bus.pc_IdEx, x_pc);
        chk({tag, "_instr_IdEx"}, bus.instr_IdEx, x_ins);
        chk({tag, "_rs_IdEx"}, bus.rs_IdEx, x_rs);
        chk({tag, "_rt_IdEx"}, bus.rt_IdEx, x_rt);
        chk({tag, "_ext_IdEx"}, bus.ext_IdEx, x_ext);
    endtask

    task automatic comb_phase();
        #1;
        predict();
        chk("ifStall", 32'(bus.ifStall), 32'(e_stall));
        chk("ifBranchOrJump_Id", 32'(bus.ifBranchOrJump_Id), 32'(e_redir));
        chk("pc_Id", bus.pc_Id, e_pcid);
    endtask

    task automatic edge_phase();
        x_pc  = m_pc;
        x_ins = e_stall ? 32'd0 : m_ins;
        x_rs  = e_stall ? 32'd0 : e_rs;
        x_rt  = e_stall ? 32'd0 : e_rt;
        x_ext = e_stall ? 32'd0 : e_ext;
        @(posedge clk);
        @(negedge clk);
        if (bus.wb_wen && bus.wb_wreg != 0) m_grf[bus.wb_wreg] = bus.wb_data;
        if (!e_stall) begin
            m_pc  = bus.pc_IfId;
            m_ins = bus.instr_IfId;
        end
        chk_idex("edge");
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
        bus.pc_IfId    = pc;
        bus.instr_IfId = ins;
    endtask

    task automatic idle_inputs();
        bus.ex_wen = 0; bus.ex_isload = 0; bus.ex_wreg = 0;
        bus.mem_wen = 0; bus.mem_isload = 0; bus.mem_wreg = 0; bus.mem_data = 0;
        bus.wb_wen = 0; bus.wb_wreg = 0; bus.wb_data = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_grf[i] = 0;
        m_pc = 32'h3000; m_ins = 0;
        x_pc = 32'h3000; x_ins = 0; x_rs = 0; x_rt = 0; x_ext = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] r;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        r   = $urandom;
        case ($urandom_range(0, 11))
            0:  return rtype(rs, rt, rd, 6'h21);
            1:  return rtype(rs, rt, rd, 6'h23);
            2:  return rtype(rs, 5'd0, 5'd0, 6'h08);
            3:  return itype(6'h0D, rs, rt, imm);
            4:  return itype(6'h23, rs, rt, imm);
            5:  return itype(6'h2B, rs, rt, imm);
            6:  return itype(6'h04, rs, rt, imm);
            7:  return itype(6'h05, rs, rt, imm);
            8:  return itype(6'h0F, 5'd0, rt, imm);
            9:  return jtype(6'h02, r[25:0]);
            10: return jtype(6'h03, r[25:0]);
            default: return {6'h3F, r[25:0]};
        endcase
    endfunction

    logic [31:0] addu_a, addu9, pc_r;

    initial begin
        reset = 0;
        idle_inputs();
        fetch(32'h0, 32'h0);
        model_reset();

        // Reset held with clock running
        repeat (3) @(negedge clk);
        chk("rst_ifStall", 32'(bus.ifStall), 32'd0);
        chk("rst_redir", 32'(bus.ifBranchOrJump_Id), 32'd0);
        chk_idex("rst");

        // First fetched word reaches ID/EX after two edges
        reset = 1;
        addu_a = rtype(5'd5, 5'd7, 5'd6, 6'h21);
        fetch(32'h3000, addu_a); comb_phase(); edge_phase();
        fetch(32'h3004, 32'h0);  comb_phase(); edge_phase();
        chk("first_word", bus.instr_IdEx, addu_a);

        // Write-through and $0 immutability
        fetch(32'h3008, rtype(5'd5, 5'd0, 5'd6, 6'h21)); comb_phase(); edge_phase();
        bus.wb_wen = 1; bus.wb_wreg = 5; bus.wb_data = 32'h1234;
        fetch(32'h300C, rtype(5'd0, 5'd0, 5'd6, 6'h21)); comb_phase(); edge_phase();
        chk("writethrough_rs", bus.rs_IdEx, 32'h1234);
        bus.wb_wreg = 0; bus.wb_data = 32'hDEAD;
        fetch(32'h3010, rtype(5'd0, 5'd5, 5'd7, 6'h21)); comb_phase(); edge_phase();
        chk("r0_write_ignored", bus.rs_IdEx, 32'h0);
        idle_inputs(); comb_phase(); edge_phase();
        chk("r0_still_zero", bus.rs_IdEx, 32'h0);
        chk("grf_r5", bus.rt_IdEx, 32'h1234);

        // Load-use stall
        addu9 = rtype(5'd8, 5'd8, 5'd9, 6'h21);
        fetch(32'h3010, addu9); comb_phase(); edge_phase();
        bus.ex_wen = 1; bus.ex_isload = 1; bus.ex_wreg = 8;
        fetch(32'h3014, 32'h0);
        comb_phase();
        chk("loaduse_stall", 32'(bus.ifStall), 32'd1);
        edge_phase();
        chk("loaduse_bubble", bus.instr_IdEx, 32'h0);
        idle_inputs(); comb_phase();
        chk("loaduse_clear", 32'(bus.ifStall), 32'd0);
        edge_phase();
        chk("loaduse_held", bus.instr_IdEx, addu9);

        // beq resolution, forwarding and branch-operand stall
        bus.wb_wen = 1; bus.wb_wreg = 1; bus.wb_data = 7;
        fetch(32'h3000, 32'h0); comb_phase(); edge_phase();
        bus.wb_wreg = 2;
        fetch(32'h3010, itype(6'h04, 5'd1, 5'd2, 16'd3)); comb_phase(); edge_phase();
        idle_inputs(); comb_phase();
        chk("beq_taken", 32'(bus.ifBranchOrJump_Id), 32'd1);
        chk("beq_target", bus.pc_Id, 32'h3020);
        bus.wb_wen = 1; bus.wb_wreg = 2; bus.wb_data = 8;
        comb_phase();
        chk("beq_not_taken", 32'(bus.ifBranchOrJump_Id), 32'd0);
        idle_inputs(); bus.ex_wen = 1; bus.ex_wreg = 1;
        comb_phase();
        chk("beq_ex_stall", 32'(bus.ifStall), 32'd1);
        chk("beq_stall_noredir", 32'(bus.ifBranchOrJump_Id), 32'd0);
        edge_phase();
        idle_inputs();

        // jal target, then jr through MEM forwarding
        fetch(32'h3000, jtype(6'h03, 26'h0C05)); comb_phase(); edge_phase();
        fetch(32'h3004, rtype(5'd31, 5'd0, 5'd0, 6'h08)); comb_phase();
        chk("jal_target", bus.pc_Id, 32'h3014);
        chk("jal_redir", 32'(bus.ifBranchOrJump_Id), 32'd1);
        edge_phase();
        bus.mem_wen = 1; bus.mem_wreg = 31; bus.mem_data = 32'h3008;
        fetch(32'h3008, addu9); comb_phase();
        chk("jr_target", bus.pc_Id, 32'h3008);
        edge_phase();

        // Asynchronous reset in the middle of a stall
        idle_inputs(); bus.ex_wen = 1; bus.ex_isload = 1; bus.ex_wreg = 8;
        comb_phase();
        chk("pre_reset_stall", 32'(bus.ifStall), 32'd1);
        #2 reset = 0;
        #1;
        chk("async_rst_stall", 32'(bus.ifStall), 32'd0);
        model_reset();
        chk_idex("async_rst");
        @(negedge clk);
        idle_inputs();
        reset = 1;

        // Randomized traffic
        pc_r = 32'h3000;
        for (int n = 0; n < 400; n++) begin
            bus.ex_wen     = 1'($urandom_range(0, 1));
            bus.ex_isload  = 1'($urandom_range(0, 1));
            bus.ex_wreg    = 5'($urandom_range(0, 7));
            bus.mem_wen    = 1'($urandom_range(0, 1));
            bus.mem_isload = 1'($urandom_range(0, 1));
            bus.mem_wreg   = 5'($urandom_range(0, 7));
            bus.mem_data   = ($urandom_range(0, 3) == 0) ? 32'd5 : $urandom;
            bus.wb_wen     = ($urandom_range(0, 9) < 7);
            bus.wb_wreg    = 5'($urandom_range(0, 7));
            bus.wb_data    = ($urandom_range(0, 3) == 0) ? 32'd5 : $urandom;
            pc_r = pc_r + 32'd4;
            fetch(pc_r, rand_instr());
            comb_phase();
            edge_phase();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage. It owns:
- the IF/ID pipeline register;
- the 32x32 general register file (GRF), including the write-back port;
- branch/jump resolution that feeds the fetch stage (pc_Id, ifBranchOrJump_Id);
- load-use / branch-operand hazard stalling (ifStall);
- the ID/EX pipeline register.

Branches are delayed: the instruction fetched while a branch sits in ID always executes.

Parameters:
RESET_PC, 32'h00003000, PC value loaded into the IF/ID and ID/EX registers on reset.
NREGS, 32, GRF depth. Index 0 is hardwired to zero.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
pc_IfId  in  32  PC of the fetched instruction
instr_IfId  in  32  fetched instruction word
ex_wen, ex_isload  in  1,1  EX-stage instruction writes GRF / is lw
ex_wreg  in  5  EX-stage destination register
mem_wen, mem_isload  in  1,1  MEM-stage instruction writes GRF / is lw
mem_wreg  in  5  MEM-stage destination register
mem_data  in  32  MEM-stage ALU result (forward source)
wb_wen  in  1  GRF write enable
wb_wreg  in  5  GRF write address
wb_data  in  32  GRF write data
ifStall  out  1  hold PC and IF/ID
ifBranchOrJump_Id  out  1  redirect fetch to pc_Id
pc_Id  out  32  redirect target
pc_IdEx, instr_IdEx  out  32,32  ID/EX PC and instruction (0 = nop)
rs_IdEx, rt_IdEx, ext_IdEx  out  32 each  forwarded operands, extended immediate

Behaviour:
- Reset (reset=0, asynchronous):
  - IF/ID pc=RESET_PC, instr=0.
  - ID/EX pc=RESET_PC, instr/rs/rt/ext=0.
  - All GRF entries = 0.
  - Outputs are valid (ifStall=0, ifBranchOrJump_Id=0) while reset is held.
  - Reset takes priority over every other event.
- IF/ID register: at posedge, loads pc_IfId/instr_IfId when ifStall=0; holds when ifStall=1.
- Decode (from the IF/ID instruction):
  - Supported: R-type addu(21h), subu(23h), jr(08h); ori(0Dh), lw(23h), sw(2Bh), beq(04h), bne(05h), lui(0Fh), j(02h), jal(03h).
  - Uses rs: all supported instructions except j, jal, lui.
  - Uses rt: addu, subu, beq, bne, sw.
  - Unknown opcode: uses no registers and does not redirect.
- GRF:
  - Write at posedge when wb_wen=1 and wb_wreg!=0. Writes to $0 are ignored.
  - Reads are combinational.
- Operand forwarding (per source s ∈ {rs, rt}, s!=0), in priority order:
  1. mem_wen & !mem_isload & mem_wreg==s → mem_data
  2. wb_wen & wb_wreg==s → wb_data (write-through)
  3. otherwise → GRF read value
  - Source $0 always reads 0.
- Stall (combinational), asserted for source s!=0 that the instruction uses when:
  - the instruction is beq/bne/jr and ex_wen & ex_wreg==s; or
  - the instruction is beq/bne/jr and mem_wen & mem_isload & mem_wreg==s; or
  - any other instruction and ex_wen & ex_isload & ex_wreg==s.
- Redirect (ifBranchOrJump_Id=0 whenever ifStall=1):
  - beq taken when forwarded rs==rt; bne taken when rs!=rt.
  - Branch target = pc+4 + (sext(imm16)<<2).
  - j/jal: target = {(pc+4)[31:28], instr[25:0], 2'b00}.
  - jr: target = forwarded rs.
  - Otherwise pc_Id = pc+4 with ifBranchOrJump_Id=0.
- Extended immediate:
  - ori: zero-extend.
  - lui: {imm16, 16'h0}.
  - others: sign-extend.
- ID/EX register:
  - At posedge, loads decoded values when ifStall=0.
  - When ifStall=1, loads a bubble: instr=0, rs/rt/ext=0, pc = current IF/ID pc.
- Arithmetic is 32-bit wrap-around; no overflow detection.
- Simultaneous WB write to a register and an ID read of it: the read returns wb_data in the same cycle.

Test Plan:
1. Hold reset=0 with clk running → GRF reads 0; instr_IdEx=0; pc_IdEx=0x3000; ifStall=0. Release reset → the first fetched word appears in ID/EX after 2 edges.
2. Issue wb write $5=0x1234, then addu $6,$5,$0 in ID in the same cycle → rs_IdEx=0x1234 next edge. Issue a wb write to $0 → $0 stays 0.
3. lw $8 in EX (ex_isload=1, ex_wreg=8), addu $9,$8,$8 in ID → ifStall=1 for 1 cycle, IF/ID held, instr_IdEx=0. Next cycle with no hazard → ifStall=0.
4. pc=0x3010, beq $1,$2,+3 with $1=$2=7 → ifBranchOrJump_Id=1, pc_Id=0x3020. With $2=8 → 0. With ex_wreg=1 and ex_wen=1 → ifStall=1, redirect=0.
5. pc=0x3000, jal 0x0C05 → pc_Id=0x00003014, redirect=1. jr $31 with mem_data forwarding 0x3008 → pc_Id=0x3008.
6. Assert reset mid-stall → IF/ID and ID/EX clear immediately without waiting for a clock edge; ifStall drops to 0.
